// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and width-legality helper for the PISO serializer
// Purpose: FSM state encoding and the legal WIDTH range used by piso_serializer.
// Ports: none (package).
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_WIDTH_MIN = 2;
  localparam int PISO_WIDTH_MAX = 64;

  function automatic bit piso_width_legal(input int width);
    return (width >= PISO_WIDTH_MIN) && (width <= PISO_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - CNT_W-bit up counter with clear, enable and terminal flag
// Purpose: tracks the bit position of the word being serialised.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   i_clr      synchronous clear to 0 (wins over i_en)
//   i_en       increment by one
//   o_count    current count
//   o_terminal count equals TERMINAL
module piso_bit_counter #(
  parameter int               CNT_W    = 3,
  parameter logic [CNT_W-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shifter with valid/ready load and stall
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit
//   per shift_en cycle, LSB or MSB first; back-to-back words stream without a gap.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   load_valid/ready    load handshake, load_data is the word
//   shift_en            consumer takes the current bit (0 = stall)
//   ser_out, ser_valid  serial bit and its qualifier
//   frame_start         ser_out is bit 0 of a word
//   frame_done          last bit of a word is consumed this cycle
//   busy                a word is in flight
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  generate
    if (!piso_width_legal(WIDTH)) begin : g_bad_width
      $error("piso_serializer: WIDTH out of range 2..64");
    end
  endgenerate

  piso_state_t      r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0] w_count;
  logic             w_last;
  logic             w_shifting;
  logic             w_frame_done;
  logic             w_load_fire;
  logic             w_tap;

  assign w_shifting   = (r_state == SHIFT) && shift_en;
  assign w_frame_done = w_shifting && w_last;
  // The last consumed bit frees the register in the same cycle, so a new
  // word can be taken on that edge without an idle bubble.
  assign load_ready   = (r_state == IDLE) || w_frame_done;
  assign w_load_fire  = load_valid && load_ready;

  // Clearing on frame_done keeps the counter at 0 in IDLE, so it never
  // relies on overflow to wrap when WIDTH is not a power of two.
  piso_bit_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (LAST_IDX)
  ) u_bit_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_load_fire || w_frame_done),
    .i_en       (w_shifting),
    .o_count    (w_count),
    .o_terminal (w_last)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      assign w_tap        = r_shift[WIDTH-1];
    end else begin : g_lsb
      assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
      assign w_tap        = r_shift[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_shift <= load_data;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (w_last && load_valid) begin
              r_shift <= load_data;
            end else if (w_last) begin
              r_shift <= w_shift_next;
              r_state <= IDLE;
            end else begin
              r_shift <= w_shift_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_valid   = (r_state == SHIFT);
  assign busy        = (r_state == SHIFT);
  assign ser_out     = ser_valid && w_tap;
  assign frame_start = ser_valid && (w_count == '0);
  assign frame_done  = w_frame_done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (4-bit LSB-first, 8-bit MSB-first)
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       a_lv, a_se, a_rdy, a_out, a_val, a_fs, a_fd, a_busy;
  logic [3:0] a_ld;
  logic       b_lv, b_se, b_rdy, b_out, b_val, b_fs, b_fd, b_busy;
  logic [7:0] b_ld;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .load_valid(a_lv), .load_data(a_ld),
    .load_ready(a_rdy), .shift_en(a_se), .ser_out(a_out), .ser_valid(a_val),
    .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .load_valid(b_lv), .load_data(b_ld),
    .load_ready(b_rdy), .shift_en(b_se), .ser_out(b_out), .ser_valid(b_val),
    .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each instance holds the bits still to be emitted, in emission order.
  bit qa[$];
  bit qb[$];

  logic [15:0] cap_a;
  int          ncap_a;
  int          fd_a;
  logic [15:0] cap_b;
  int          ncap_b;
  int          busy_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    cap_a = '0; ncap_a = 0; fd_a = 0;
    cap_b = '0; ncap_b = 0; busy_b = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a.ser_out"},     64'(a_out),  64'(0));
    check({tag, ".a.ser_valid"},   64'(a_val),  64'(0));
    check({tag, ".a.frame_start"}, 64'(a_fs),   64'(0));
    check({tag, ".a.frame_done"},  64'(a_fd),   64'(0));
    check({tag, ".a.busy"},        64'(a_busy), 64'(0));
    check({tag, ".b.ser_out"},     64'(b_out),  64'(0));
    check({tag, ".b.ser_valid"},   64'(b_val),  64'(0));
    check({tag, ".b.busy"},        64'(b_busy), 64'(0));
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step(input logic lva, input logic [3:0] lda, input logic sea,
                      input logic lvb, input logic [7:0] ldb, input logic seb);
    bit ea_v, ea_rdy, ea_bit, eb_v, eb_rdy, eb_bit;
    @(negedge clk);
    a_lv = lva; a_ld = lda; a_se = sea;
    b_lv = lvb; b_ld = ldb; b_se = seb;
    #1;
    ea_v   = (qa.size() != 0);
    ea_bit = 1'b0;
    if (ea_v) ea_bit = qa[0];
    ea_rdy = !ea_v || (sea && qa.size() == 1);
    check("a.ser_valid",   64'(a_val),  64'(ea_v));
    check("a.busy",        64'(a_busy), 64'(ea_v));
    check("a.ser_out",     64'(a_out),  64'(ea_bit));
    check("a.frame_start", 64'(a_fs),   64'(qa.size() == 4));
    check("a.frame_done",  64'(a_fd),   64'(ea_v && sea && qa.size() == 1));
    check("a.load_ready",  64'(a_rdy),  64'(ea_rdy));

    eb_v   = (qb.size() != 0);
    eb_bit = 1'b0;
    if (eb_v) eb_bit = qb[0];
    eb_rdy = !eb_v || (seb && qb.size() == 1);
    check("b.ser_valid",   64'(b_val),  64'(eb_v));
    check("b.busy",        64'(b_busy), 64'(eb_v));
    check("b.ser_out",     64'(b_out),  64'(eb_bit));
    check("b.frame_start", 64'(b_fs),   64'(qb.size() == 8));
    check("b.frame_done",  64'(b_fd),   64'(eb_v && seb && qb.size() == 1));
    check("b.load_ready",  64'(b_rdy),  64'(eb_rdy));

    if (a_val === 1'b1 && sea) begin cap_a = {cap_a[14:0], a_out}; ncap_a++; end
    if (a_fd === 1'b1) fd_a++;
    if (b_val === 1'b1 && seb) begin cap_b = {cap_b[14:0], b_out}; ncap_b++; end
    if (b_busy === 1'b1) busy_b++;

    @(posedge clk);
    if (ea_v && sea) void'(qa.pop_front());
    if (lva && ea_rdy) for (int i = 0; i < 4; i++) qa.push_back(lda[i]);
    if (eb_v && seb) void'(qb.pop_front());
    if (lvb && eb_rdy) for (int i = 0; i < 8; i++) qb.push_back(ldb[7-i]);
  endtask

  initial begin
    logic [1:0] t5_se [6];
    reset_n = 1'b0;
    a_lv = 0; a_ld = '0; a_se = 0;
    b_lv = 0; b_ld = '0; b_se = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset.a.load_ready", 64'(a_rdy), 64'(1));
    check("reset.b.load_ready", 64'(b_rdy), 64'(1));

    // 4'b1101 LSB-first and 8'hA5 MSB-first, no stalls
    clear_caps();
    step(1, 4'b1101, 1, 1, 8'hA5, 1);
    repeat (9) step(0, 4'b0, 1, 0, 8'h0, 1);
    check("t1.a.stream", 64'(cap_a), 64'(4'b1011));
    check("t1.a.nbits",  64'(ncap_a), 64'(4));
    check("t2.b.stream", 64'(cap_b), 64'(8'hA5));
    check("t2.b.busy_cycles", 64'(busy_b), 64'(8));

    // back-to-back: second word held valid until accepted on the last bit
    clear_caps();
    step(1, 4'b1101, 1, 0, 8'h0, 0);
    repeat (4) step(1, 4'b1001, 1, 0, 8'h0, 0);
    repeat (5) step(0, 4'b0, 1, 0, 8'h0, 0);
    check("t3.a.stream", 64'(cap_a), 64'(8'b10111001));
    check("t3.a.nbits",  64'(ncap_a), 64'(8));
    check("t3.a.frame_done_count", 64'(fd_a), 64'(2));

    // stall for 3 cycles after the first bit is consumed
    clear_caps();
    step(1, 4'b0110, 1, 0, 8'h0, 0);
    step(0, 4'b0, 1, 0, 8'h0, 0);
    repeat (3) step(0, 4'b0, 0, 0, 8'h0, 0);
    repeat (4) step(0, 4'b0, 1, 0, 8'h0, 0);
    check("t4.a.stream", 64'(cap_a), 64'(4'b0110));
    check("t4.a.frame_done_count", 64'(fd_a), 64'(1));

    // load attempt while busy, with stalls; 1111 only enters after 0011 completes
    clear_caps();
    t5_se = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    step(1, 4'b0011, 1, 0, 8'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 4'b1111, t5_se[i][0], 0, 8'h0, 0);
    repeat (5) step(0, 4'b0, 1, 0, 8'h0, 0);
    check("t5.a.stream", 64'(cap_a), 64'(8'b11001111));
    check("t5.a.nbits",  64'(ncap_a), 64'(8));

    // asynchronous reset during the second bit
    step(1, 4'b1101, 1, 1, 8'hA5, 1);
    step(0, 4'b0, 1, 0, 8'h0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6.async");
    qa.delete();
    qb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 4'b0, 1, 0, 8'h0, 1);
    step(1, 4'b1001, 1, 1, 8'h3C, 1);
    step(0, 4'b0, 1, 0, 8'h0, 1);
    #1;
    check("t6.a.ser_valid_after", 64'(a_val), 64'(1));

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'(($urandom % 4) != 0),
           1'($urandom_range(0, 1)), 8'($urandom), 1'(($urandom % 4) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
